// File: rtl/if_id_stage.sv
// PC register and IF/ID pipeline register for the fetch front of the 5-stage pipeline.
// Optional IF_ID_PERF_CNT_EN adds saturating STALL_CNT / FLUSH_CNT performance counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] PC_IF_ID,
  output logic [31:0] INSTR_IF_ID,
  output logic        VALID_IF_ID,
  output logic [4:0]  ARS1_IF_ID,
  output logic [4:0]  ARS2_IF_ID,
  output logic [4:0]  ARD_IF_ID
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
`endif
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_if_id_reg, pc_if_id_next;
  logic [31:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;

  // Flush beats stall: the squashed slot has nothing worth holding.
  always_comb begin
    pc_next       = pc_reg;
    pc_if_id_next = pc_if_id_reg;
    instr_next    = instr_reg;
    valid_next    = valid_reg;
    if (FLUSH) begin
      pc_next       = {BRANCH_TARGET[31:2], 2'b00};
      pc_if_id_next = 32'h0000_0000;
      instr_next    = NOP_INSTR;
      valid_next    = 1'b0;
    end else if (!STALL) begin
      pc_next       = pc_reg + 32'd4;
      pc_if_id_next = pc_reg;
      instr_next    = IMEM_DATA;
      valid_next    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_reg       <= RESET_PC;
      pc_if_id_reg <= 32'h0000_0000;
      instr_reg    <= NOP_INSTR;
      valid_reg    <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      pc_if_id_reg <= pc_if_id_next;
      instr_reg    <= instr_next;
      valid_reg    <= valid_next;
    end
  end

  assign IMEM_ADDR   = pc_reg;
  assign PC_IF_ID    = pc_if_id_reg;
  assign INSTR_IF_ID = instr_reg;
  assign VALID_IF_ID = valid_reg;

  // Register fields read as zero for a bubble so it never matches a real destination.
  localparam int FIELD_LSB [3] = '{15, 20, 7};
  logic [4:0] field [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
      assign field[gi] = valid_reg ? instr_reg[FIELD_LSB[gi] +: 5] : 5'd0;
    end
  endgenerate

  assign ARS1_IF_ID = field[0];
  assign ARS2_IF_ID = field[1];
  assign ARD_IF_ID  = field[2];

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt_reg <= 32'h0000_0000;
      flush_cnt_reg <= 32'h0000_0000;
    end else begin
      if (STALL && !FLUSH && stall_cnt_reg != 32'hFFFF_FFFF)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (FLUSH && flush_cnt_reg != 32'hFFFF_FFFF)
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign STALL_CNT = stall_cnt_reg;
  assign FLUSH_CNT = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: abstract fetch model compared every cycle plus
// directed literal checks; honours IF_ID_PERF_CNT_EN when defined.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic [31:0] branch_target, imem_addr, imem_data;
  logic [31:0] pc_if_id, instr_if_id;
  logic        valid_if_id;
  logic [4:0]  ars1, ars2, ard;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  if_id_stage dut (
    .CLK(clk), .RST_N(rst_n), .STALL(stall), .FLUSH(flush),
    .BRANCH_TARGET(branch_target), .IMEM_ADDR(imem_addr), .IMEM_DATA(imem_data),
    .PC_IF_ID(pc_if_id), .INSTR_IF_ID(instr_if_id), .VALID_IF_ID(valid_if_id),
    .ARS1_IF_ID(ars1), .ARS2_IF_ID(ars2), .ARD_IF_ID(ard)
`ifdef IF_ID_PERF_CNT_EN
    , .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction ROM: word0 = add x3,x5,x6 ; word1 = add x9,x7,x8 ; rest arbitrary.
  logic [31:0] rom [16] = '{
    32'h0062_81B3, 32'h0083_84B3, 32'hA5A5_1234, 32'h0F0F_F0F0,
    32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h8000_0001,
    32'h7FFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h5555_AAAA,
    32'h0013_0513, 32'h00B5_0633, 32'h3C3C_C3C3, 32'h9696_6969};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return rom[a[5:2]] ^ {a[31:6], 6'b0};
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Abstract model: fetch state as plain variables following the edge priority rules.
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_pcid, m_ins, m_scnt, m_fcnt;
  logic        m_v;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known <= 1'b1;
      m_pc <= 32'h0; m_pcid <= 32'h0; m_ins <= 32'h13; m_v <= 1'b0;
      m_scnt <= 32'h0; m_fcnt <= 32'h0;
    end else begin
      if (flush) begin
        m_pc <= branch_target & ~32'd3; m_pcid <= 32'h0; m_ins <= 32'h13; m_v <= 1'b0;
      end else if (!stall) begin
        m_pc <= m_pc + 32'd4; m_pcid <= m_pc; m_ins <= mem_word(m_pc); m_v <= 1'b1;
      end
      if (stall && !flush && m_scnt != 32'hFFFF_FFFF) m_scnt <= m_scnt + 1;
      if (flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt <= m_fcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_pc_if_id", pc_if_id, m_pcid);
      chk("m_instr", instr_if_id, m_ins);
      chk("m_valid", {31'b0, valid_if_id}, {31'b0, m_v});
      chk("m_ars1", {27'b0, ars1}, m_v ? {27'b0, m_ins[19:15]} : 32'h0);
      chk("m_ars2", {27'b0, ars2}, m_v ? {27'b0, m_ins[24:20]} : 32'h0);
      chk("m_ard",  {27'b0, ard},  m_v ? {27'b0, m_ins[11:7]}  : 32'h0);
`ifdef IF_ID_PERF_CNT_EN
      chk("m_stall_cnt", stall_cnt, m_scnt);
      chk("m_flush_cnt", flush_cnt, m_fcnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed stall/flush pattern for a mixed stretch: {flush, stall} per cycle.
  logic [1:0] pat [16] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01,
                           2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = 32'h0;
    tick(); tick();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr_if_id, 32'h13);
    chk("rst_valid", {31'b0, valid_if_id}, 32'h0);
    chk("rst_ars", {17'b0, ars1, ars2, ard}, 32'h0);

    rst_n = 1'b1;
    tick();
    chk("s1_addr", imem_addr, 32'h4);
    chk("s1_pc", pc_if_id, 32'h0);
    chk("s1_instr", instr_if_id, 32'h0062_81B3);
    chk("s1_fields", {17'b0, ars1, ars2, ard}, {17'b0, 5'd5, 5'd6, 5'd3});
    tick();
    chk("s2_addr", imem_addr, 32'h8);
    chk("s2_pc", pc_if_id, 32'h4);
    chk("s2_fields", {17'b0, ars1, ars2, ard}, {17'b0, 5'd7, 5'd8, 5'd9});

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_pc", pc_if_id, 32'h4);
    end
    stall = 1'b0;
    tick();
    chk("rel_pc", pc_if_id, 32'h8);
    chk("rel_addr", imem_addr, 32'hC);

    flush = 1'b1; stall = 1'b1; branch_target = 32'h40;
    tick();
    chk("fl_addr", imem_addr, 32'h40);
    chk("fl_valid", {31'b0, valid_if_id}, 32'h0);
    chk("fl_instr", instr_if_id, 32'h13);
    chk("fl_ard", {27'b0, ard}, 32'h0);
    flush = 1'b0; stall = 1'b0;
    tick();
    chk("fl2_pc", pc_if_id, 32'h40);
    chk("fl2_valid", {31'b0, valid_if_id}, 32'h1);

    flush = 1'b1; branch_target = 32'hFFFF_FFFE;
    tick();
    chk("wrap_align", imem_addr, 32'hFFFF_FFFC);
    flush = 1'b0;
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", pc_if_id, 32'hFFFF_FFFC);

    stall = 1'b1; rst_n = 1'b0;
    tick();
    chk("rst_stall_valid", {31'b0, valid_if_id}, 32'h0);
    stall = 1'b0; flush = 1'b1; branch_target = 32'h80;
    tick();
    chk("rst_flush_addr", imem_addr, 32'h0);
    flush = 1'b0; rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      flush = pat[i][1]; stall = pat[i][0]; branch_target = 32'h100 + 32'(i * 12);
      tick();
    end
    flush = 1'b0; stall = 1'b0;

`ifdef IF_ID_PERF_CNT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; stall = 1'b1;
    tick(); tick(); tick();
    flush = 1'b1; stall = 1'b0; branch_target = 32'h20;
    tick();
    stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("perf_stall", stall_cnt, 32'd3);
    chk("perf_flush", flush_cnt, 32'd2);
    rst_n = 1'b0;
    tick();
    chk("perf_rst", stall_cnt | flush_cnt, 32'd0);
    rst_n = 1'b1;
`endif
    tick(); tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
